// File: rtl/button_events_if.sv
// -----------------------------------------------------------------------------
// button_events_if
// Bundles the pad input and the debounced event outputs of button_events.
//   btn_raw        : unsynchronized pad level (driven by the pad / bench)
//   btn_level      : debounced state, 1 = pressed
//   press_pulse    : one-cycle pulse on accepted press
//   release_pulse  : one-cycle pulse on accepted release
//   short_pulse    : one-cycle pulse on release before the long threshold
//   long_pulse     : one-cycle pulse when the long threshold is reached
//   press_count    : accepted presses, modulo 256
// master drives the pad, slave is the button_events block.
// -----------------------------------------------------------------------------
interface button_events_if;
  logic       btn_raw;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  modport master (
    output btn_raw,
    input  btn_level, press_pulse, release_pulse, short_pulse, long_pulse,
           press_count
  );

  modport slave (
    input  btn_raw,
    output btn_level, press_pulse, release_pulse, short_pulse, long_pulse,
           press_count
  );
endinterface

// File: rtl/button_events.sv
// -----------------------------------------------------------------------------
// button_events
// Debounced push-button front end: two-flop synchronizer, bounce filter,
// press / release / short / long event pulses and a wrapping press counter.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : button_events_if.slave (btn_raw in, debounced level/events out)
// Parameters:
//   DEBOUNCE_CYCLES : cycles a new level must persist before acceptance (>= 2)
//   LONG_CYCLES     : press duration that qualifies as a long press
//   ACTIVE_LOW      : 1 = pad reads 0 when pressed
// All outputs are registered; nothing combinational reaches them from btn_raw.
// -----------------------------------------------------------------------------
module button_events #(
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int LONG_CYCLES     = 48000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  button_events_if.slave bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  logic              p;
  logic              s1_q, s2_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              level_q, level_d;
  logic              accept;
  logic              press_acc, rel_acc;
  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              short_q, short_d;
  logic              long_q, long_d;
  logic [7:0]        count_q, count_d;

  // Active-high pressed level regardless of pad polarity.
  assign p = ACTIVE_LOW ? ~bus.btn_raw : bus.btn_raw;

  // Debounce: the synchronized level must disagree with the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    accept   = 1'b0;
    if (s2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
      accept   = 1'b1;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  assign press_acc = accept & ~level_q;
  assign rel_acc   = accept &  level_q;

  // Event FSM. Pulses are computed here and registered so they line up with
  // the cycle in which btn_level first shows the new value.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    count_d    = count_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_acc) begin
          state_d    = ST_PRESSED;
          press_d    = 1'b1;
          count_d    = count_q + 8'd1;
          hold_cnt_d = '0;
        end
      end
      ST_PRESSED: begin
        // A release accepted in the threshold cycle still counts as short.
        if (rel_acc) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_HELD;
          long_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_HELD: begin
        if (rel_acc) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      db_cnt_q   <= '0;
      level_q    <= 1'b0;
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      s1_q       <= p;
      s2_q       <= s1_q;
      db_cnt_q   <= db_cnt_d;
      level_q    <= level_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      short_q    <= short_d;
      long_q     <= long_d;
      count_q    <= count_d;
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.short_pulse   = short_q;
  assign bus.long_pulse    = long_q;
  assign bus.press_count   = count_q;

endmodule

// File: doc/button_events.md
# button_events

Debounced push-button front end for UPduino designs: synchronizes a raw pad input, filters contact bounce, and reports press, release, short-press, and long-press events as single-cycle pulses. It also keeps a wrapping press counter. It is the input counterpart to the on-board LED drivers: LED/colour sequencing logic consumes its events, on the 48 MHz SB_HFOSC clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 480000: consecutive cycles a new level must persist before it is accepted (10 ms at 48 MHz); legal range ≥ 2.
- `LONG_CYCLES`, default 48000000: press duration that qualifies as a long press (1 s at 48 MHz); must be greater than `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, default 1: 1 means the pad reads 0 when pressed; 0 means the pad reads 1 when pressed.
- `clk`  in  1  system clock (SB_HFOSC output).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_raw`  in  1  unsynchronized pad level.
- `btn_level`  out  1  debounced state; 1 = pressed.
- `press_pulse`  out  1  one-cycle pulse on accepted press.
- `release_pulse`  out  1  one-cycle pulse on accepted release.
- `short_pulse`  out  1  one-cycle pulse on release before the long threshold.
- `long_pulse`  out  1  one-cycle pulse when the long threshold is reached while held.
- `press_count`  out  8  number of accepted presses, modulo 256.

## Operation
- **Normalize:** `ACTIVE_LOW` converts the pad to an active-high level `p`.
- **Synchronizer:** two flops, `s1` then `s2`. Both reset to 0 (released).
- **Debounce counter:**
  - Width is `$clog2(DEBOUNCE_CYCLES)`.
  - If `s2 == btn_level`, the counter clears to 0.
  - Otherwise, if the counter equals `DEBOUNCE_CYCLES-1`, then `btn_level` toggles and the counter clears.
  - Otherwise, the counter increments.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `btn_level`.
- **FSM states:**
  - IDLE: released.
  - PRESSED: held, long threshold not yet reached.
  - HELD: long press already reported.
- **FSM transitions:**
  - IDLE to PRESSED on accepted press. In that cycle: `press_pulse` asserts, `press_count` increments, and the hold counter clears to 0.
  - PRESSED: the hold counter (width `$clog2(LONG_CYCLES)`) increments each cycle.
  - PRESSED to HELD when the hold counter equals `LONG_CYCLES-1` and no release is accepted in that cycle; `long_pulse` asserts.
  - PRESSED to IDLE on accepted release; `release_pulse` and `short_pulse` assert together.
  - HELD to IDLE on accepted release; only `release_pulse` asserts.
- **Simultaneous release and long threshold in the same cycle:** release wins. `short_pulse` and `release_pulse` assert; `long_pulse` does not; next state is IDLE.
- **Counter wrap:** `press_count` wraps 255 → 0 with no flag.
- **Pulse exclusivity:** at most one of `press_pulse`, `long_pulse`, `release_pulse` is high in any cycle. `short_pulse` only ever accompanies `release_pulse`.

## Timing
- **Reset:** all state is reset. `btn_level`=0, all pulses 0, `press_count`=0, FSM=IDLE, counters=0.
  - Asserting `rst_n` mid-press drops everything immediately, with no release pulse.
  - After reset deassert, a button still held is accepted as a new press after the normal debounce latency.
- **Input latency:** `btn_raw` changes before clock edge 0 and stays stable. `btn_level` updates at edge `DEBOUNCE_CYCLES+1`: two sync stages plus `DEBOUNCE_CYCLES` mismatch cycles.
- **Event pulses:** `press_pulse`, `release_pulse` and `short_pulse` are registered and high during the same cycle in which `btn_level` first shows the new value.
- **Long press:** `long_pulse` is high exactly `LONG_CYCLES` cycles after the `press_pulse` cycle.
- **Outputs:** all outputs come directly from flops; there is no combinational path from `btn_raw`.

## Test plan
Tests 1–4 use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `ACTIVE_LOW`=1.
1. **Reset.** Hold `rst_n`=0 with `btn_raw` toggling → all outputs 0. Release reset with `btn_raw`=1 (released) for 50 cycles → no pulses.
2. **Clean press.** Drive `btn_raw`=0 before edge 0:
   - `btn_level`=1 and `press_pulse`=1 at edge 5; `press_count`=1.
   - Release after 10 cycles held → `release_pulse` and `short_pulse` together, exactly 5 edges after the raw change.
3. **Bounce rejection.** 3-cycle low glitches separated by 1-cycle highs, repeated 10 times → `btn_level` stays 0, no pulses. Then hold low → press accepted 5 edges after the final falling transition.
4. **Long press.**
   - Hold pressed → `long_pulse` 20 cycles after `press_pulse`, once only.
   - Release → `release_pulse` without `short_pulse`.
   - Separate case: release accepted exactly in the threshold cycle → `short_pulse`, no `long_pulse`.
5. **Counter wrap** (`DEBOUNCE_CYCLES`=2). Issue 257 clean presses → `press_count` reads 255 after 255 presses, 0 after 256, 1 after 257.
6. **`ACTIVE_LOW`=0 and reset mid-hold.** Press with `btn_raw`=1 → same latency as test 2. Assert `rst_n` while in HELD → outputs 0 immediately, with no `release_pulse`.
